// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO family: gray conversion, storage styles, sync limits.
package fifo_pkg;
  localparam int    GRAY_MAX_W      = 32;
  localparam int    MIN_SYNC_STAGES = 2;
  localparam string RAM_STYLE_DIST  = "distributed";
  localparam string RAM_STYLE_BLOCK = "block";
  localparam string RAM_STYLE_REG   = "registers";

  // Width-generic: callers zero-extend to GRAY_MAX_W and cast the result back to their width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/cdc_gray_sync.sv
// Gray-pointer synchroniser: STAGES destination-clock cycles of latency, no handshake;
// the source must change at most one bit per update.
module cdc_gray_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO with registered full/empty, programmable thresholds and per-side counts.
// Flags/counts lag the far side by SYNC_STAGES+1 cycles; writes while full and reads while empty are dropped and pulse overflow/underflow.
module async_fifo_prog
  import fifo_pkg::*;
#(
  parameter int    DATA_WIDTH        = 8,
  parameter int    ADDR_WIDTH        = 4,
  parameter int    SYNC_STAGES       = 2,
  parameter bit    FWFT_EN           = 1'b1,
  parameter int    PROG_FULL_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int    PROG_EMPTY_THRESH = 2,
  parameter string RAM_STYLE         = RAM_STYLE_DIST
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  prog_full,
  output logic [ADDR_WIDTH:0]   wr_data_count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH:0]   rd_data_count,
  output logic                  underflow
);
  localparam int PW     = ADDR_WIDTH + 1;
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam logic [PW-1:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PF_TH     = PW'(PROG_FULL_THRESH);
  localparam logic [PW-1:0] PE_TH     = PW'(PROG_EMPTY_THRESH);

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wptr, wptr_next, wptr_gray, rptr_gray_sync, rptr_sync, wr_cnt_next;
  logic [PW-1:0] rptr, rptr_next, rptr_gray, wptr_gray_sync, wptr_sync, rd_cnt_next;
  logic          wr_acc, rd_acc, empty_next;

  // ---------------- write domain ----------------
  assign wr_acc      = wr_en & ~full;
  assign wptr_next   = wptr + PW'(wr_acc);
  assign rptr_sync   = PW'(gray2bin(GRAY_MAX_W'(rptr_gray_sync)));
  assign wr_cnt_next = wptr_next - rptr_sync;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wptr          <= '0;
      wptr_gray     <= '0;
      full          <= 1'b1;
      prog_full     <= 1'b1;
      wr_data_count <= '0;
      overflow      <= 1'b0;
    end else begin
      wptr          <= wptr_next;
      wptr_gray     <= PW'(bin2gray(GRAY_MAX_W'(wptr_next)));
      full          <= (wr_cnt_next == DEPTH_CNT);
      prog_full     <= (wr_cnt_next >= PF_TH);
      wr_data_count <= wr_cnt_next;
      overflow      <= wr_en & full;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= din;
  end

  cdc_gray_sync #(.WIDTH(PW), .STAGES(STAGES)) u_rptr_sync (
    .clk (wr_clk),
    .rst (wr_rst),
    .d   (rptr_gray),
    .q   (rptr_gray_sync)
  );

  // ---------------- read domain ----------------
  assign rd_acc      = rd_en & ~empty;
  assign rptr_next   = rptr + PW'(rd_acc);
  assign wptr_sync   = PW'(gray2bin(GRAY_MAX_W'(wptr_gray_sync)));
  assign rd_cnt_next = wptr_sync - rptr_next;
  assign empty_next  = (wptr_sync == rptr_next);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rptr          <= '0;
      rptr_gray     <= '0;
      empty         <= 1'b1;
      prog_empty    <= 1'b1;
      rd_data_count <= '0;
      underflow     <= 1'b0;
    end else begin
      rptr          <= rptr_next;
      rptr_gray     <= PW'(bin2gray(GRAY_MAX_W'(rptr_next)));
      empty         <= empty_next;
      prog_empty    <= (rd_cnt_next <= PE_TH);
      rd_data_count <= rd_cnt_next;
      underflow     <= rd_en & empty;
    end
  end

  generate
    if (FWFT_EN) begin : g_fwft
      // Prefetch the next head each cycle; once drained, the last popped word stays visible.
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)           dout <= '0;
        else if (!empty_next) dout <= mem[rptr_next[ADDR_WIDTH-1:0]];
      end
    end else begin : g_std
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)      dout <= '0;
        else if (rd_acc) dout <= mem[rptr[ADDR_WIDTH-1:0]];
      end
    end
  endgenerate

  cdc_gray_sync #(.WIDTH(PW), .STAGES(STAGES)) u_wptr_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wptr_gray),
    .q   (wptr_gray_sync)
  );
endmodule
